// File: rtl/wall_renderer_pkg.sv
// Shared constants, state encoding and the gap test for the wall renderer.
package wall_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int WALL_WIDTH  = 4;
  localparam int WALL_HEIGHT = 120;
  localparam int GAP_H       = 30;

  localparam logic [2:0] WALL_COLOUR = 3'b010;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  localparam int DX_W = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
  localparam int Y_W  = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERASE = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ERASE = ST_ERASE,
    S_DRAW  = ST_DRAW,
    S_DONE  = ST_DONE
  } state_t;

  // The gap end is formed at 8 bits, so a gap running off the bottom is just truncated.
  function automatic logic in_gap(input logic [Y_W-1:0] y, input logic [6:0] gap_top);
    logic [7:0] gap_end;
    gap_end = {1'b0, gap_top} + 8'(GAP_H);
    return ({1'b0, y} >= {1'b0, gap_top}) && ({1'b0, y} < gap_end);
  endfunction

endpackage

// File: rtl/wall_renderer_if.sv
// Request and pixel-write bundle between the wall control logic, renderer and VGA adapter.
interface wall_renderer_if;
  logic       start;
  logic [7:0] wall_x;
  logic [6:0] gap_y;
  logic       plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       busy;
  logic       done;

  modport master (
    output start, wall_x, gap_y,
    input  plot, x_out, y_out, colour, busy, done
  );

  modport slave (
    input  start, wall_x, gap_y,
    output plot, x_out, y_out, colour, busy, done
  );
endinterface

// File: rtl/wall_renderer_pixel_scan_counter.sv
// Row-major dx/y slot counter shared by the erase and draw passes.
module pixel_scan_counter
  import wall_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [DX_W-1:0] dx_nxt,
  output logic [Y_W-1:0]  y_nxt,
  output logic            last
);

  logic [DX_W-1:0] dx;
  logic [Y_W-1:0]  y;

  // Slot that follows the one currently being presented; wraps to 0,0 after the last.
  always_comb begin
    dx_nxt = dx + 1'b1;
    y_nxt  = y;
    if (dx == DX_W'(WALL_WIDTH - 1)) begin
      dx_nxt = '0;
      y_nxt  = (y == Y_W'(WALL_HEIGHT - 1)) ? '0 : y + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx   <= '0;
      y    <= '0;
      last <= 1'b0;
    end else if (clear) begin
      dx   <= '0;
      y    <= '0;
      last <= 1'b0;
    end else if (enable) begin
      dx   <= dx_nxt;
      y    <= y_nxt;
      last <= (dx_nxt == DX_W'(WALL_WIDTH - 1)) && (y_nxt == Y_W'(WALL_HEIGHT - 1));
    end
  end

endmodule

// File: rtl/wall_renderer.sv
// Turns a wall position into one registered pixel write per clock for the VGA adapter.
// Define WALL_ERASE_EN to erase the previously drawn wall before each draw.
//   state | meaning
//   IDLE  | waiting for start
//   ERASE | repaint old wall position in background colour
//   DRAW  | paint wall at latched position, gap in background colour
//   DONE  | one-cycle completion pulse
module wall_renderer
  import wall_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  wall_renderer_if.slave bus
);

  state_t          state;
  logic [7:0]      lat_x;
  logic [6:0]      lat_gap;
`ifdef WALL_ERASE_EN
  logic [7:0]      prev_x;
`endif

  logic            scan_clear;
  logic            scan_en;
  logic [DX_W-1:0] dx_nxt;
  logic [Y_W-1:0]  y_nxt;
  logic            scan_last;

  logic [7:0]      src_base;
  logic [DX_W-1:0] src_dx;
  logic [Y_W-1:0]  src_y;
  logic [6:0]      src_gap;
  logic            src_draw;
  logic [8:0]      px_x9;
  logic            px_plot;
  logic [2:0]      px_colour;

  assign scan_clear = (state == S_IDLE);
  assign scan_en    = (state == S_ERASE) || (state == S_DRAW);

  pixel_scan_counter u_scan (
    .clk    (clk),
    .reset  (reset),
    .clear  (scan_clear),
    .enable (scan_en),
    .dx_nxt (dx_nxt),
    .y_nxt  (y_nxt),
    .last   (scan_last)
  );

  // Pixel to be registered on the coming edge: slot 0 on start, else the next slot.
  always_comb begin
    src_base = lat_x;
    src_dx   = dx_nxt;
    src_y    = y_nxt;
    src_gap  = lat_gap;
    src_draw = 1'b1;
    if (state == S_IDLE) begin
      src_dx  = '0;
      src_y   = '0;
      src_gap = bus.gap_y;
`ifdef WALL_ERASE_EN
      src_base = prev_x;
      src_draw = 1'b0;
`else
      src_base = bus.wall_x;
`endif
    end
`ifdef WALL_ERASE_EN
    else if ((state == S_ERASE) && !scan_last) begin
      src_base = prev_x;
      src_draw = 1'b0;
    end
`endif
    px_x9     = {1'b0, src_base} + {{(9-DX_W){1'b0}}, src_dx};
    px_plot   = (px_x9 < 9'(SCREEN_W));
    px_colour = (src_draw && !in_gap(src_y, src_gap)) ? WALL_COLOUR : BG_COLOUR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_x      <= '0;
      lat_gap    <= '0;
`ifdef WALL_ERASE_EN
      prev_x     <= 8'(SCREEN_W);
`endif
      bus.plot   <= 1'b0;
      bus.x_out  <= '0;
      bus.y_out  <= '0;
      bus.colour <= BG_COLOUR;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.plot <= 1'b0;
          if (bus.start) begin
            lat_x      <= bus.wall_x;
            lat_gap    <= bus.gap_y;
            bus.busy   <= 1'b1;
            bus.plot   <= px_plot;
            bus.x_out  <= px_x9[7:0];
            bus.y_out  <= src_y;
            bus.colour <= px_colour;
`ifdef WALL_ERASE_EN
            state      <= S_ERASE;
`else
            state      <= S_DRAW;
`endif
          end
        end
`ifdef WALL_ERASE_EN
        S_ERASE: begin
          bus.plot   <= px_plot;
          bus.x_out  <= px_x9[7:0];
          bus.y_out  <= src_y;
          bus.colour <= px_colour;
          if (scan_last) state <= S_DRAW;
        end
`endif
        S_DRAW: begin
          if (scan_last) begin
            state    <= S_DONE;
            bus.plot <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
`ifdef WALL_ERASE_EN
            prev_x   <= lat_x;
`endif
          end else begin
            bus.plot   <= px_plot;
            bus.x_out  <= px_x9[7:0];
            bus.y_out  <= src_y;
            bus.colour <= px_colour;
          end
        end
        S_DONE: begin
          bus.plot <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.plot <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wall_renderer.sv
// Directed and randomized redraws checked cycle by cycle against a slot-list model.
module tb_wall_renderer;
  import wall_pkg::*;

`ifdef WALL_ERASE_EN
  localparam bit ERASE_ON = 1'b1;
`else
  localparam bit ERASE_ON = 1'b0;
`endif
  localparam int PHASE  = WALL_WIDTH * WALL_HEIGHT;
  localparam int N_DONE = ERASE_ON ? 2 * PHASE : PHASE;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wall_renderer_if bus ();
  wall_renderer dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int model_prev = SCREEN_W;
  int nplot;

  bit exp_plot[$];
  int exp_x[$];
  int exp_y[$];
  int exp_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One entry per pixel slot, in the order the screen is scanned.
  function automatic void add_phase(input int base, input int gy, input bit draw);
    for (int y = 0; y < WALL_HEIGHT; y++)
      for (int dx = 0; dx < WALL_WIDTH; dx++) begin
        int x;
        bit gap;
        x   = base + dx;
        gap = (y >= gy) && (y < gy + GAP_H);
        exp_plot.push_back(x < SCREEN_W);
        exp_x.push_back(x % 256);
        exp_y.push_back(y);
        exp_c.push_back((draw && !gap) ? int'(WALL_COLOUR) : int'(BG_COLOUR));
      end
  endfunction

  function automatic void build(input int wx, input int gy);
    exp_plot.delete(); exp_x.delete(); exp_y.delete(); exp_c.delete();
    if (ERASE_ON) add_phase(model_prev, 0, 1'b0);
    add_phase(wx, gy, 1'b1);
  endfunction

  task automatic redraw(input string name, input int wx, input int gy,
                        input int rst_cyc, input int ign_cyc, output int plots);
    plots = 0;
    build(wx, gy);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.wall_x = 8'(wx);
    bus.gap_y  = 7'(gy);
    for (int c = 0; c <= N_DONE + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) bus.start = 1'b0;
      if (c < N_DONE) begin
        chk({name, " plot"}, bus.plot, exp_plot[c]);
        if (exp_plot[c]) begin
          chk({name, " x"}, bus.x_out, exp_x[c]);
          chk({name, " y"}, bus.y_out, exp_y[c]);
          chk({name, " colour"}, bus.colour, exp_c[c]);
        end
        chk({name, " busy"}, bus.busy, 1);
        chk({name, " done"}, bus.done, 0);
        if (bus.plot === 1'b1) plots++;
      end else if (c == N_DONE) begin
        chk({name, " done_pulse"}, bus.done, 1);
        chk({name, " busy_at_done"}, bus.busy, 0);
        chk({name, " plot_at_done"}, bus.plot, 0);
      end else begin
        chk({name, " done_after"}, bus.done, 0);
        chk({name, " busy_after"}, bus.busy, 0);
        chk({name, " plot_after"}, bus.plot, 0);
      end
      if (c == ign_cyc) begin
        bus.start  = 1'b1;
        bus.wall_x = 8'd7;
        bus.gap_y  = 7'd3;
      end else if (c == ign_cyc + 1) begin
        bus.start = 1'b0;
      end
      if (c == rst_cyc) begin
        #2 reset = 1'b1;
        #1;
        chk({name, " rst_plot"}, bus.plot, 0);
        chk({name, " rst_busy"}, bus.busy, 0);
        chk({name, " rst_done"}, bus.done, 0);
        chk({name, " rst_colour"}, bus.colour, BG_COLOUR);
        @(negedge clk);
        reset      = 1'b0;
        model_prev = SCREEN_W;
        return;
      end
    end
    model_prev = wx;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.wall_x = '0;
    bus.gap_y  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset plot", bus.plot, 0);
    chk("reset x", bus.x_out, 0);
    chk("reset y", bus.y_out, 0);
    chk("reset colour", bus.colour, BG_COLOUR);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;

    redraw("first", 100, 40, -1, -1, p);
    chk("first plots", p, 480);
    redraw("second", 96, 40, -1, -1, p);
    chk("second plots", p, ERASE_ON ? 960 : 480);
    redraw("clip158", 158, 10, -1, -1, p);
    chk("clip158 plots", p, ERASE_ON ? 720 : 240);
    redraw("clip254", 254, 10, -1, -1, p);
    chk("clip254 plots", p, ERASE_ON ? 240 : 0);
    redraw("gap100", 30, 100, -1, 300, p);
    chk("gap100 plots", p, ERASE_ON ? 480 : 480);
    redraw("midreset", 20, 50, ERASE_ON ? 600 : 300, -1, p);
    redraw("after_rst", 60, 0, -1, -1, p);
    chk("after_rst plots", p, 480);
    redraw("x50", 50, 5, -1, -1, p);
    chk("x50 plots", p, ERASE_ON ? 960 : 480);

    for (int i = 0; i < 5; i++) begin
      redraw($sformatf("rand%0d", i), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 127)), -1, -1, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
